// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with sync/enable delay line and a frame-divided game tick.
// Coordinates and ticks are registered once; h_sync/v_sync/display_area get SYNC_DELAY more stages.
module vga_timing_gen #(
   parameter int unsigned H_DISPLAY  = 640,
   parameter int unsigned H_FRONT    = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BACK     = 48,
   parameter int unsigned V_DISPLAY  = 480,
   parameter int unsigned V_FRONT    = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BACK     = 33,
   parameter bit          H_SYNC_POL = 1'b0,
   parameter bit          V_SYNC_POL = 1'b0,
   parameter int unsigned CNT_W      = 10,
   parameter int unsigned CELL_LOG2  = 4,
   parameter int unsigned SYNC_DELAY = 2,
   parameter int unsigned TICK_DIV   = 8,
   parameter int unsigned TICK_W     = 3
) (
   input  logic                       clock_25,
   input  logic                       reset,
   input  logic                       enable,
   output logic                       h_sync,
   output logic                       v_sync,
   output logic                       display_area,
   output logic [CNT_W-1:0]           x,
   output logic [CNT_W-1:0]           y,
   output logic [CNT_W-CELL_LOG2-1:0] cell_x,
   output logic [CNT_W-CELL_LOG2-1:0] cell_y,
   output logic                       line_tick,
   output logic                       frame_tick,
   output logic                       game_tick
);

   localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [CNT_W-1:0]  H_LAST    = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0]  V_LAST    = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0]  H_ACT     = CNT_W'(H_DISPLAY);
   localparam logic [CNT_W-1:0]  V_ACT     = CNT_W'(V_DISPLAY);
   localparam logic [CNT_W-1:0]  HS_START  = CNT_W'(H_DISPLAY + H_FRONT);
   localparam logic [CNT_W-1:0]  HS_END    = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [CNT_W-1:0]  VS_START  = CNT_W'(V_DISPLAY + V_FRONT);
   localparam logic [CNT_W-1:0]  VS_END    = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC);
   localparam logic [TICK_W-1:0] FDIV_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic              H_IDLE    = ~H_SYNC_POL;
   localparam logic              V_IDLE    = ~V_SYNC_POL;

   logic [CNT_W-1:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic [TICK_W-1:0] fdiv_q, fdiv_d;
   logic [CNT_W-1:0]  x_q, x_d, y_q, y_d;
   logic              de_q, de_d, hs_q, hs_d, vs_q, vs_d;
   logic              line_q, line_d, frame_q, frame_d, game_q, game_d;

   always_comb begin
      h_cnt_d = h_cnt_q + CNT_W'(1);
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
      end

      de_d    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      x_d     = de_d ? h_cnt_q : '0;
      y_d     = de_d ? v_cnt_q : '0;
      // Sync levels carry their polarity into the flop so the pins come straight off a register.
      hs_d    = (h_cnt_q >= HS_START && h_cnt_q < HS_END) ? H_SYNC_POL : H_IDLE;
      vs_d    = (v_cnt_q >= VS_START && v_cnt_q < VS_END) ? V_SYNC_POL : V_IDLE;
      line_d  = (h_cnt_q == '0);
      frame_d = line_d && (v_cnt_q == V_ACT);
      game_d  = frame_d && (fdiv_q == FDIV_LAST);

      fdiv_d = fdiv_q;
      if (frame_d) begin
         fdiv_d = (fdiv_q == FDIV_LAST) ? '0 : fdiv_q + TICK_W'(1);
      end
   end

   always_ff @(posedge clock_25 or negedge reset) begin
      if (!reset) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         fdiv_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
         de_q    <= 1'b0;
         hs_q    <= H_IDLE;
         vs_q    <= V_IDLE;
         line_q  <= 1'b0;
         frame_q <= 1'b0;
         game_q  <= 1'b0;
      end else if (enable) begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         fdiv_q  <= fdiv_d;
         x_q     <= x_d;
         y_q     <= y_d;
         de_q    <= de_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         line_q  <= line_d;
         frame_q <= frame_d;
         game_q  <= game_d;
      end else begin
         line_q  <= 1'b0;
         frame_q <= 1'b0;
         game_q  <= 1'b0;
      end
   end

   if (SYNC_DELAY == 0) begin : g_no_delay
      assign display_area = de_q;
      assign h_sync       = hs_q;
      assign v_sync       = vs_q;
   end else begin : g_delay
      logic [SYNC_DELAY-1:0] de_pipe, hs_pipe, vs_pipe;

      always_ff @(posedge clock_25 or negedge reset) begin
         if (!reset) begin
            de_pipe <= '0;
            hs_pipe <= {SYNC_DELAY{H_IDLE}};
            vs_pipe <= {SYNC_DELAY{V_IDLE}};
         end else if (enable) begin
            de_pipe <= (de_pipe << 1) | SYNC_DELAY'(de_q);
            hs_pipe <= (hs_pipe << 1) | SYNC_DELAY'(hs_q);
            vs_pipe <= (vs_pipe << 1) | SYNC_DELAY'(vs_q);
         end
      end

      assign display_area = de_pipe[SYNC_DELAY-1];
      assign h_sync       = hs_pipe[SYNC_DELAY-1];
      assign v_sync       = vs_pipe[SYNC_DELAY-1];
   end

   assign x          = x_q;
   assign y          = y_q;
   assign cell_x     = x_q[CNT_W-1:CELL_LOG2];
   assign cell_y     = y_q[CNT_W-1:CELL_LOG2];
   assign line_tick  = line_q;
   assign frame_tick = frame_q;
   assign game_tick  = game_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full 640x480 timing for one-line checks, plus two scaled rasters
// (32x19 totals) for frame, divider, enable-freeze, polarity and async reset scenarios.
`timescale 1ns / 1ps
module tb_vga_timing_gen;

   logic clock_25 = 1'b0;
   always #5 clock_25 = ~clock_25;

   int checks = 0;
   int errors = 0;

   // Full-size instance, default parameters
   logic       rst0 = 1'b0, en0 = 1'b0;
   logic       hs0, vs0, de0, lt0, ft0, gt0;
   logic [9:0] x0, y0;
   logic [5:0] cx0, cy0;

   vga_timing_gen u_full (
      .clock_25(clock_25), .reset(rst0), .enable(en0),
      .h_sync(hs0), .v_sync(vs0), .display_area(de0), .x(x0), .y(y0),
      .cell_x(cx0), .cell_y(cy0), .line_tick(lt0), .frame_tick(ft0), .game_tick(gt0)
   );

   // Scaled raster: H 16/4/6/6 = 32, V 12/2/2/3 = 19, frame = 608 clocks
   logic       rst1 = 1'b0, en1 = 1'b0;
   logic       hs1, vs1, de1, lt1, ft1, gt1;
   logic [5:0] x1, y1;
   logic [3:0] cx1, cy1;

   vga_timing_gen #(
      .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
      .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
      .CNT_W(6), .CELL_LOG2(2), .SYNC_DELAY(2), .TICK_DIV(8), .TICK_W(3)
   ) u_small (
      .clock_25(clock_25), .reset(rst1), .enable(en1),
      .h_sync(hs1), .v_sync(vs1), .display_area(de1), .x(x1), .y(y1),
      .cell_x(cx1), .cell_y(cy1), .line_tick(lt1), .frame_tick(ft1), .game_tick(gt1)
   );

   // Same raster, active-high syncs, no extra delay, game tick every frame
   logic       rst2 = 1'b0, en2 = 1'b0;
   logic       hs2, vs2, de2, lt2, ft2, gt2;
   logic [5:0] x2, y2;
   logic [3:0] cx2, cy2;

   vga_timing_gen #(
      .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
      .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
      .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1),
      .CNT_W(6), .CELL_LOG2(2), .SYNC_DELAY(0), .TICK_DIV(1), .TICK_W(1)
   ) u_pol (
      .clock_25(clock_25), .reset(rst2), .enable(en2),
      .h_sync(hs2), .v_sync(vs2), .display_area(de2), .x(x2), .y(y2),
      .cell_x(cx2), .cell_y(cy2), .line_tick(lt2), .frame_tick(ft2), .game_tick(gt2)
   );

   task automatic step();
      @(posedge clock_25);
      #1;
   endtask

   task automatic test_reset();
      rst0 = 1'b0;
      en0  = 1'b1;
      repeat (3) step();
      checks++;
      if ({hs0, vs0, de0, lt0, ft0, gt0} !== 6'b110000) begin
         errors++;
         $display("FAIL reset_flags got %b want 110000", {hs0, vs0, de0, lt0, ft0, gt0});
      end
      checks++;
      if ({x0, y0, cx0, cy0} !== 32'd0) begin
         errors++;
         $display("FAIL reset_coords got x=%0d y=%0d cx=%0d cy=%0d want all 0", x0, y0, cx0, cy0);
      end
      rst0 = 1'b1;
      step();
      checks++;
      if ({lt0, ft0, de0, x0, y0} !== {1'b1, 1'b0, 1'b0, 20'd0}) begin
         errors++;
         $display("FAIL first_edge got lt=%b ft=%b de=%b x=%0d y=%0d want lt=1 ft=0 de=0 x=0 y=0",
                  lt0, ft0, de0, x0, y0);
      end
      step();
      checks++;
      if (de0 !== 1'b0) begin
         errors++;
         $display("FAIL de_latency2 got %b want 0", de0);
      end
      step();
      checks++;
      if (de0 !== 1'b1) begin
         errors++;
         $display("FAIL de_latency3 got %b want 1", de0);
      end
   endtask

   task automatic test_line();
      logic [9:0] ex, ey;
      logic       elt, ede, ehs;
      int         n, m, h, v;
      rst0 = 1'b0;
      en0  = 1'b1;
      step();
      rst0 = 1'b1;
      for (int k = 1; k <= 1700; k++) begin
         step();
         n   = k - 1;
         m   = k - 3;
         h   = n % 800;
         v   = n / 800;
         ex  = (h < 640) ? 10'(h) : 10'd0;
         ey  = (h < 640) ? 10'(v) : 10'd0;
         elt = (h == 0);
         ede = (m >= 0) && ((m % 800) < 640);
         ehs = !((m >= 0) && ((m % 800) >= 656) && ((m % 800) < 752));
         checks++;
         if ({x0, y0, cx0, cy0, lt0, ft0, gt0, de0, hs0, vs0} !==
             {ex, ey, ex[9:4], ey[9:4], elt, 1'b0, 1'b0, ede, ehs, 1'b1}) begin
            errors++;
            $display("FAIL line k=%0d got x=%0d y=%0d cx=%0d cy=%0d lt=%b ft=%b gt=%b de=%b hs=%b vs=%b want x=%0d y=%0d lt=%b de=%b hs=%b vs=1",
                     k, x0, y0, cx0, cy0, lt0, ft0, gt0, de0, hs0, vs0, ex, ey, elt, ede, ehs);
         end
      end
      rst0 = 1'b0;
   endtask

   task automatic test_frames();
      logic [5:0] ex, ey;
      logic       elt, eft, egt, ede, ehs, evs;
      int         n, m, h, v, f, hm, vm;
      int         n_frame = 0, n_game = 0;
      rst1 = 1'b0;
      en1  = 1'b1;
      step();
      rst1 = 1'b1;
      for (int k = 1; k <= 17 * 608 + 8; k++) begin
         step();
         n   = k - 1;
         m   = k - 3;
         h   = n % 32;
         v   = (n / 32) % 19;
         f   = n / 608;
         hm  = m % 32;
         vm  = (m / 32) % 19;
         ex  = (h < 16 && v < 12) ? 6'(h) : 6'd0;
         ey  = (h < 16 && v < 12) ? 6'(v) : 6'd0;
         elt = (h == 0);
         eft = (h == 0) && (v == 12);
         egt = eft && ((f + 1) % 8 == 0);
         ede = (m >= 0) && (hm < 16) && (vm < 12);
         ehs = !((m >= 0) && (hm >= 20) && (hm < 26));
         evs = !((m >= 0) && (vm >= 14) && (vm < 16));
         if (ft1 === 1'b1) n_frame++;
         if (gt1 === 1'b1) n_game++;
         checks++;
         if ({x1, y1, cx1, cy1, lt1, ft1, gt1, de1, hs1, vs1} !==
             {ex, ey, ex[5:2], ey[5:2], elt, eft, egt, ede, ehs, evs}) begin
            errors++;
            $display("FAIL frame k=%0d got x=%0d y=%0d cy=%0d lt=%b ft=%b gt=%b de=%b hs=%b vs=%b want x=%0d y=%0d cy=%0d lt=%b ft=%b gt=%b de=%b hs=%b vs=%b",
                     k, x1, y1, cy1, lt1, ft1, gt1, de1, hs1, vs1,
                     ex, ey, ey[5:2], elt, eft, egt, ede, ehs, evs);
         end
      end
      checks++;
      if (n_frame != 17 || n_game != 2) begin
         errors++;
         $display("FAIL tick_counts got frames=%0d games=%0d want frames=17 games=2", n_frame, n_game);
      end
   endtask

   task automatic test_enable();
      int cnt;
      bit found;
      rst1 = 1'b0;
      en1  = 1'b1;
      step();
      rst1 = 1'b1;
      repeat (11) step();
      checks++;
      if (x1 !== 6'd10) begin
         errors++;
         $display("FAIL pre_freeze_x got %0d want 10", x1);
      end
      en1 = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step();
         checks++;
         if ({x1, lt1, ft1, gt1, de1, hs1} !== {6'd10, 5'b00011}) begin
            errors++;
            $display("FAIL freeze i=%0d got x=%0d lt=%b ft=%b gt=%b de=%b hs=%b want x=10 lt=0 ft=0 gt=0 de=1 hs=1",
                     i, x1, lt1, ft1, gt1, de1, hs1);
         end
      end
      en1 = 1'b1;
      step();
      checks++;
      if (x1 !== 6'd11) begin
         errors++;
         $display("FAIL resume_x1 got %0d want 11", x1);
      end
      step();
      checks++;
      if (x1 !== 6'd12) begin
         errors++;
         $display("FAIL resume_x2 got %0d want 12", x1);
      end
      repeat (20) step();
      checks++;
      if ({lt1, x1, y1} !== {1'b1, 6'd0, 6'd1}) begin
         errors++;
         $display("FAIL line1_start got lt=%b x=%0d y=%0d want lt=1 x=0 y=1", lt1, x1, y1);
      end
      // One frozen edge right after a line_tick: the pulse must drop, not hold.
      en1 = 1'b0;
      step();
      checks++;
      if ({lt1, x1, y1} !== {1'b0, 6'd0, 6'd1}) begin
         errors++;
         $display("FAIL tick_forced_low got lt=%b x=%0d y=%0d want lt=0 x=0 y=1", lt1, x1, y1);
      end
      en1 = 1'b1;
      step();
      checks++;
      if ({lt1, x1} !== {1'b0, 6'd1}) begin
         errors++;
         $display("FAIL resume_line1 got lt=%b x=%0d want lt=0 x=1", lt1, x1);
      end
      cnt   = 0;
      found = 1'b0;
      for (int i = 0; i < 1000 && !found; i++) begin
         step();
         cnt++;
         if (ft1 === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found || cnt != 351) begin
         errors++;
         $display("FAIL stalled_frame_tick got found=%0d after=%0d want found=1 after=351", found, cnt);
      end
      step();
      checks++;
      if (ft1 !== 1'b0) begin
         errors++;
         $display("FAIL frame_tick_width got %b want 0", ft1);
      end
      cnt   = 1;
      found = 1'b0;
      for (int i = 0; i < 700 && !found; i++) begin
         step();
         cnt++;
         if (ft1 === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found || cnt != 608) begin
         errors++;
         $display("FAIL frame_period got found=%0d period=%0d want found=1 period=608", found, cnt);
      end
      rst1 = 1'b0;
   endtask

   task automatic test_polarity();
      logic [5:0] ex, ey;
      logic       elt, eft, ede, ehs, evs;
      int         n, h, v;
      rst2 = 1'b0;
      en2  = 1'b1;
      step();
      rst2 = 1'b1;
      for (int k = 1; k <= 3 * 608; k++) begin
         step();
         n   = k - 1;
         h   = n % 32;
         v   = (n / 32) % 19;
         ex  = (h < 16 && v < 12) ? 6'(h) : 6'd0;
         ey  = (h < 16 && v < 12) ? 6'(v) : 6'd0;
         elt = (h == 0);
         eft = (h == 0) && (v == 12);
         ede = (h < 16) && (v < 12);
         ehs = (h >= 20) && (h < 26);
         evs = (v >= 14) && (v < 16);
         checks++;
         if ({x2, y2, lt2, ft2, gt2, de2, hs2, vs2} !== {ex, ey, elt, eft, eft, ede, ehs, evs}) begin
            errors++;
            $display("FAIL polarity k=%0d got x=%0d y=%0d lt=%b ft=%b gt=%b de=%b hs=%b vs=%b want x=%0d y=%0d lt=%b ft=%b gt=%b de=%b hs=%b vs=%b",
                     k, x2, y2, lt2, ft2, gt2, de2, hs2, vs2, ex, ey, elt, eft, eft, ede, ehs, evs);
         end
      end
   endtask

   task automatic test_async_reset();
      rst2 = 1'b0;
      en2  = 1'b1;
      step();
      rst2 = 1'b1;
      repeat (5 * 32 + 9) step();
      checks++;
      if ({x2, y2, de2} !== {6'd8, 6'd5, 1'b1}) begin
         errors++;
         $display("FAIL pre_reset_active got x=%0d y=%0d de=%b want x=8 y=5 de=1", x2, y2, de2);
      end
      #3 rst2 = 1'b0;
      #1;
      checks++;
      if ({x2, y2, cx2, cy2, de2} !== 21'd0) begin
         errors++;
         $display("FAIL async_reset_coords got x=%0d y=%0d cx=%0d cy=%0d de=%b want all 0",
                  x2, y2, cx2, cy2, de2);
      end
      step();
      rst2 = 1'b1;
      repeat (5 * 32 + 22) step();
      checks++;
      if (hs2 !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_hsync got %b want 1", hs2);
      end
      #3 rst2 = 1'b0;
      #1;
      checks++;
      if ({hs2, vs2, lt2, ft2, gt2} !== 5'b00000) begin
         errors++;
         $display("FAIL async_reset_sync got hs=%b vs=%b lt=%b ft=%b gt=%b want all 0",
                  hs2, vs2, lt2, ft2, gt2);
      end
      step();
      rst2 = 1'b1;
      step();
      checks++;
      if ({lt2, ft2, de2, x2, y2} !== {3'b101, 12'd0}) begin
         errors++;
         $display("FAIL restart_origin got lt=%b ft=%b de=%b x=%0d y=%0d want lt=1 ft=0 de=1 x=0 y=0",
                  lt2, ft2, de2, x2, y2);
      end
   endtask

   initial begin
      test_reset();
      test_line();
      test_frames();
      test_enable();
      test_polarity();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
